// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one external combinational ALU between two requesters.
// A granted request is latched onto the ALU inputs, the result is captured one cycle later and
// held on the owner's response channel until that owner consumes it. One transaction in flight.
module alu_share_arbiter #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned OPW  = 8
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic [1:0]      i_req_valid,
   output logic [1:0]      o_req_ready,
   input  logic [OPW-1:0]  i_req_opcode0,
   input  logic [OPW-1:0]  i_req_opcode1,
   input  logic [XLEN-1:0] i_req_op1_0,
   input  logic [XLEN-1:0] i_req_op1_1,
   input  logic [XLEN-1:0] i_req_op2_0,
   input  logic [XLEN-1:0] i_req_op2_1,
   output logic [1:0]      o_rsp_valid,
   input  logic [1:0]      i_rsp_ready,
   output logic [XLEN-1:0] o_rsp_result,
   output logic [OPW-1:0]  o_alu_opcode,
   output logic [XLEN-1:0] o_alu_operand1,
   output logic [XLEN-1:0] o_alu_operand2,
   input  logic [XLEN-1:0] i_alu_result,
   output logic            o_busy,
   output logic [31:0]     o_op_count
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } state_e;

   state_e          r_state;
   logic            r_last_grant;
   logic            r_owner;
   logic            r_busy;
   logic [1:0]      r_rsp_valid;
   logic [XLEN-1:0] r_rsp_result;
   logic [OPW-1:0]  r_alu_opcode;
   logic [XLEN-1:0] r_alu_operand1;
   logic [XLEN-1:0] r_alu_operand2;
   logic [31:0]     r_op_count;

   logic            w_winner;
   logic            w_accept;

   // Arbitration: a lone requester wins outright; on a tie the port not granted last time wins.
   always_comb begin
      w_winner    = (i_req_valid == 2'b11) ? ~r_last_grant : i_req_valid[1];
      w_accept    = (r_state == StIdle) && (|i_req_valid);
      o_req_ready = 2'b00;
      if (w_accept) begin
         o_req_ready[w_winner] = 1'b1;
      end
   end

   // Transaction FSM: latch winner's payload, sample ALU result, hold response until owner takes it.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state        <= StIdle;
         r_last_grant   <= 1'b1;
         r_owner        <= 1'b0;
         r_busy         <= 1'b0;
         r_rsp_valid    <= 2'b00;
         r_rsp_result   <= '0;
         r_alu_opcode   <= '0;
         r_alu_operand1 <= '0;
         r_alu_operand2 <= '0;
         r_op_count     <= 32'd0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_alu_opcode   <= w_winner ? i_req_opcode1 : i_req_opcode0;
                  r_alu_operand1 <= w_winner ? i_req_op1_1   : i_req_op1_0;
                  r_alu_operand2 <= w_winner ? i_req_op2_1   : i_req_op2_0;
                  r_owner        <= w_winner;
                  r_last_grant   <= w_winner;
                  r_busy         <= 1'b1;
                  r_state        <= StExec;
               end
            end
            StExec: begin
               r_rsp_result <= i_alu_result;
               r_rsp_valid  <= r_owner ? 2'b10 : 2'b01;
               r_state      <= StResp;
            end
            StResp: begin
               // Only the owner's ready retires the response; the other port's ready is ignored.
               if (i_rsp_ready[r_owner]) begin
                  r_rsp_valid <= 2'b00;
                  r_op_count  <= r_op_count + 32'd1;
                  r_busy      <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_rsp_valid <= 2'b00;
               r_busy      <= 1'b0;
               r_state     <= StIdle;
            end
         endcase
      end
   end

   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_result   = r_rsp_result;
   assign o_alu_opcode   = r_alu_opcode;
   assign o_alu_operand1 = r_alu_operand1;
   assign o_alu_operand2 = r_alu_operand2;
   assign o_busy         = r_busy;
   assign o_op_count     = r_op_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus for alu_share_arbiter with a small external ALU model,
// a latency-level reference model compared every cycle, and literal expectations per scenario.
module tb_alu_share_arbiter;

   localparam int XLEN = 32;
   localparam int OPW  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [OPW-1:0]  op0, op1;
   logic [XLEN-1:0] a0, b0, a1, b1;
   logic [1:0]      rsp_valid;
   logic [1:0]      rsp_ready;
   logic [XLEN-1:0] rsp_result;
   logic [OPW-1:0]  alu_op;
   logic [XLEN-1:0] alu_a, alu_b, alu_res;
   logic            busy;
   logic [31:0]     op_count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // External ALU: add, sub, sltu; anything else returns 0.
   function automatic logic [XLEN-1:0] alu_fn(input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
      case (op)
         8'h00:   return a + b;
         8'h01:   return a - b;
         8'h09:   return {{(XLEN-1){1'b0}}, (a < b)};
         default: return '0;
      endcase
   endfunction

   assign alu_res = alu_fn(alu_op, alu_a, alu_b);

   alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_opcode0  (op0),
      .i_req_opcode1  (op1),
      .i_req_op1_0    (a0),
      .i_req_op1_1    (a1),
      .i_req_op2_0    (b0),
      .i_req_op2_1    (b1),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_result   (rsp_result),
      .o_alu_opcode   (alu_op),
      .o_alu_operand1 (alu_a),
      .o_alu_operand2 (alu_b),
      .i_alu_result   (alu_res),
      .o_busy         (busy),
      .o_op_count     (op_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: transaction age counts cycles since acceptance (1 = ALU cycle, >=2 = response).
   bit              m_txn = 1'b0;
   int              m_age = 0;
   bit              m_owner = 1'b0;
   bit              m_last = 1'b1;
   logic [OPW-1:0]  m_op = '0;
   logic [XLEN-1:0] m_a = '0, m_b = '0;
   logic [XLEN-1:0] m_res = '0, m_prev_res = '0;
   logic [31:0]     m_count = '0;
   logic [1:0]      e_ready, e_rsp_valid;
   logic [XLEN-1:0] e_result;
   bit              w;

   // Per-cycle comparison against the model, then advance the model across the coming edge.
   always @(negedge clk) begin
      if (!m_txn) begin
         if (req_valid == 2'b11) e_ready = m_last ? 2'b01 : 2'b10;
         else                    e_ready = req_valid;
      end else begin
         e_ready = 2'b00;
      end
      e_rsp_valid = (m_txn && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      e_result    = (m_txn && m_age >= 2) ? m_res : m_prev_res;
      if (chk_en) begin
         chk("m_req_ready", 64'(req_ready), 64'(e_ready));
         chk("m_rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
         chk("m_rsp_result", 64'(rsp_result), 64'(e_result));
         chk("m_busy", 64'(busy), 64'(m_txn));
         chk("m_alu_opcode", 64'(alu_op), 64'(m_op));
         chk("m_alu_operand1", 64'(alu_a), 64'(m_a));
         chk("m_alu_operand2", 64'(alu_b), 64'(m_b));
         chk("m_op_count", 64'(op_count), 64'(m_count));
      end
      if (rst) begin
         m_txn = 0; m_age = 0; m_owner = 0; m_last = 1;
         m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_prev_res = '0; m_count = '0;
      end else if (!m_txn && (|req_valid)) begin
         w       = (req_valid == 2'b11) ? !m_last : req_valid[1];
         m_txn   = 1; m_age = 1; m_owner = w; m_last = w;
         m_op    = w ? op1 : op0;
         m_a     = w ? a1 : a0;
         m_b     = w ? b1 : b0;
         m_res   = alu_fn(m_op, m_a, m_b);
      end else if (m_txn) begin
         if (m_age >= 2 && rsp_ready[m_owner]) begin
            m_txn      = 0;
            m_count    = m_count + 1;
            m_prev_res = m_res;
         end else begin
            m_age = 2;
         end
      end
   end

   // Stream tables: per-port list of (opcode, op1, op2).
   logic [OPW-1:0]  s_op [2][8];
   logic [XLEN-1:0] s_a  [2][8];
   logic [XLEN-1:0] s_b  [2][8];
   int              s_n  [2];
   int              grants[$];
   logic [XLEN-1:0] results[$];

   task automatic set_entry(input int p, input int i, input logic [OPW-1:0] op,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      s_op[p][i] = op;
      s_a[p][i]  = a;
      s_b[p][i]  = b;
   endtask

   // Both requesters present their next op as soon as the previous one is accepted.
   task automatic run_stream();
      int i0 = 0;
      int i1 = 0;
      bit done = 0;
      grants.delete();
      results.delete();
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         req_valid[0] = (i0 < s_n[0]);
         req_valid[1] = (i1 < s_n[1]);
         if (i0 < s_n[0]) begin op0 = s_op[0][i0]; a0 = s_a[0][i0]; b0 = s_b[0][i0]; end
         if (i1 < s_n[1]) begin op1 = s_op[1][i1]; a1 = s_a[1][i1]; b1 = s_b[1][i1]; end
         rsp_ready = 2'b11;
         @(negedge clk);
         chk("one_grant", 64'($countones(req_ready) <= 1), 64'(1));
         if (req_ready[0] && req_valid[0]) begin grants.push_back(0); i0++; end
         if (req_ready[1] && req_valid[1]) begin grants.push_back(1); i1++; end
         if (|(rsp_valid & rsp_ready)) results.push_back(rsp_result);
         if (results.size() == s_n[0] + s_n[1]) done = 1;
         tick();
      end
      chk("stream_done", 64'(done), 64'(1));
      req_valid = 2'b00;
      rsp_ready = 2'b00;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_result", 64'(rsp_result), 64'(0));
      chk("rst_op_count", 64'(op_count), 64'(0));
      chk("rst_alu_operand1", 64'(alu_a), 64'(0));
      tick();
   endtask

   logic [XLEN-1:0] exp6 [8];
   int              gexp6 [8];
   logic [31:0]     cnt0;
   bit              idle_seen;

   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      tick();
      tick();
      rst    = 1'b0;
      chk_en = 1'b1;

      // Scenario 1: single add on port 0, 5+7.
      do_reset();
      req_valid = 2'b01; op0 = 8'h00; a0 = 32'd5; b0 = 32'd7;
      @(negedge clk);
      chk("t1_req_ready", 64'(req_ready), 64'(2'b01));
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      chk("t1_alu_opcode", 64'(alu_op), 64'(8'h00));
      chk("t1_alu_operand1", 64'(alu_a), 64'(5));
      chk("t1_alu_operand2", 64'(alu_b), 64'(7));
      chk("t1_exec_no_rsp", 64'(rsp_valid), 64'(0));
      tick();
      @(negedge clk);
      chk("t1_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      chk("t1_rsp_result", 64'(rsp_result), 64'(12));
      tick();
      rsp_ready = 2'b01;
      @(negedge clk);
      tick();
      rsp_ready = 2'b00;
      @(negedge clk);
      chk("t1_op_count", 64'(op_count), 64'(1));
      chk("t1_rsp_done", 64'(rsp_valid), 64'(0));
      tick();

      // Scenario 2: tie from reset, port 0 sub then port 1 sltu.
      do_reset();
      s_n[0] = 1; s_n[1] = 1;
      set_entry(0, 0, 8'h01, 32'd10, 32'd3);
      set_entry(1, 0, 8'h09, 32'd1, 32'd2);
      run_stream();
      chk("t2_grant_count", 64'(grants.size()), 64'(2));
      if (grants.size() == 2) begin
         chk("t2_grant0", 64'(grants[0]), 64'(0));
         chk("t2_grant1", 64'(grants[1]), 64'(1));
      end
      if (results.size() == 2) begin
         chk("t2_result0", 64'(results[0]), 64'(7));
         chk("t2_result1", 64'(results[1]), 64'(1));
      end

      // Scenarios 3 and 4: response backpressure, then non-owner ready, with port 1 waiting.
      cnt0 = op_count;
      req_valid = 2'b01; op0 = 8'h00; a0 = 32'd5; b0 = 32'd7;
      op1 = 8'h00; a1 = 32'd20; b1 = 32'd22; rsp_ready = 2'b00;
      @(negedge clk);
      chk("t3_req_ready", 64'(req_ready), 64'(2'b01));
      tick();
      req_valid = 2'b10;
      @(negedge clk);
      chk("t3_exec_ready", 64'(req_ready), 64'(0));
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_rsp_valid", 64'(rsp_valid), 64'(2'b01));
         chk("t3_rsp_result", 64'(rsp_result), 64'(12));
         chk("t3_req_ready", 64'(req_ready), 64'(0));
         chk("t3_busy", 64'(busy), 64'(1));
         tick();
      end
      rsp_ready = 2'b10;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t4_rsp_valid", 64'(rsp_valid), 64'(2'b01));
         chk("t4_op_count", 64'(op_count), 64'(cnt0));
         tick();
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      tick();
      rsp_ready = 2'b00;
      @(negedge clk);
      chk("t4_pending_grant", 64'(req_ready), 64'(2'b10));
      chk("t4_op_count_after", 64'(op_count), 64'(cnt0 + 1));
      tick();
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      idle_seen = 0;
      for (int k = 0; k < 10 && !idle_seen; k++) begin
         @(negedge clk);
         if (!busy) idle_seen = 1;
         tick();
      end
      chk("t4_drain", 64'(idle_seen), 64'(1));
      rsp_ready = 2'b00;

      // Scenario 5: reset during the ALU cycle drops the transaction.
      req_valid = 2'b01; op0 = 8'h00; a0 = 32'd9; b0 = 32'd9;
      @(negedge clk);
      chk("t5_req_ready", 64'(req_ready), 64'(2'b01));
      tick();
      req_valid = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_in_exec", 64'(busy), 64'(1));
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("t5_busy", 64'(busy), 64'(0));
      chk("t5_op_count", 64'(op_count), 64'(0));
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t5_no_late_rsp", 64'(rsp_valid), 64'(0));
         tick();
      end

      // Scenario 6: continuous requests from both ports, 8 ops, alternating grants.
      s_n[0] = 4; s_n[1] = 4;
      set_entry(0, 0, 8'h00, 32'd100, 32'd23);
      set_entry(0, 1, 8'h01, 32'd50, 32'd8);
      set_entry(0, 2, 8'hFF, 32'd1, 32'd2);
      set_entry(0, 3, 8'h09, 32'd3, 32'd2);
      set_entry(1, 0, 8'h00, 32'd1, 32'd1);
      set_entry(1, 1, 8'h09, 32'd2, 32'd3);
      set_entry(1, 2, 8'h01, 32'd0, 32'd1);
      set_entry(1, 3, 8'h00, 32'hFFFF_FFFF, 32'd1);
      exp6[0] = 32'd123; exp6[1] = 32'd2; exp6[2] = 32'd42; exp6[3] = 32'd1;
      exp6[4] = 32'd0;   exp6[5] = 32'hFFFF_FFFF; exp6[6] = 32'd0; exp6[7] = 32'd0;
      for (int k = 0; k < 8; k++) gexp6[k] = k % 2;
      run_stream();
      chk("t6_grant_count", 64'(grants.size()), 64'(8));
      chk("t6_result_count", 64'(results.size()), 64'(8));
      for (int k = 0; k < 8; k++) begin
         if (k < grants.size())  chk("t6_grant", 64'(grants[k]), 64'(gexp6[k]));
         if (k < results.size()) chk("t6_result", 64'(results[k]), 64'(exp6[k]));
      end
      @(negedge clk);
      chk("t6_op_count", 64'(op_count), 64'(8));
      chk("t6_idle", 64'(busy), 64'(0));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
